// File: rtl/snn_pkg.sv
// Shared definitions for the spike window readout stage: FSM states,
// default sizing and the saturation ceiling helper.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INTEGRATE,
    SCAN,
    REPORT
  } state_t;

  localparam int DEF_NUM_CH = 10;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WIN_W  = 16;

  // Largest value a width-w unsigned counter can hold before saturating.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Per-channel spike counter that clears on request and sticks at its
// maximum value instead of wrapping.
module sat_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_max(CNT_W));

  // Clear has priority over counting; once at the ceiling further spikes are dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != MAX_CNT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spike_window_classifier.sv
// Readout stage: integrates output-layer spikes per channel over a
// programmable window, then scans the counts once to pick the winning
// class, reporting its index, count and whether another channel tied it.
module spike_window_classifier
  import snn_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CNT_W  = DEF_CNT_W,
  parameter  int WIN_W  = DEF_WIN_W,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIN_W-1:0]  win_len_i,
  input  logic              en_i,
  input  logic [NUM_CH-1:0] spike_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              valid_o,
  output logic [IDX_W-1:0]  winner_o,
  output logic [CNT_W-1:0]  winner_count_o,
  output logic              tie_o,
  input  logic [IDX_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_count_o
);

  state_t             state;
  logic [WIN_W-1:0]   win_cnt;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   best_idx;
  logic [CNT_W-1:0]   best_cnt;
  logic               best_tie;
  logic [CNT_W-1:0]   scan_cnt;
  logic [CNT_W-1:0]   counts [NUM_CH];
  logic [NUM_CH-1:0]  count_inc;
  logic               start_ok;

  assign start_ok  = (state == IDLE) && start_i;
  assign count_inc = ((state == INTEGRATE) && en_i) ? spike_i : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk_i),
      .rst   (rst_i),
      .clear (start_ok),
      .inc   (count_inc[g]),
      .count (counts[g])
    );
  end

  // Select the channel currently under scan; a loop compare avoids out-of-range indexing.
  always_comb begin
    scan_cnt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (scan_idx == IDX_W'(c)) scan_cnt = counts[c];
    end
  end

  // Random-access readback; unused select codes read as zero.
  always_comb begin
    rd_count_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_sel_i == IDX_W'(c)) rd_count_o = counts[c];
    end
  end

  // Window / scan / report sequencer with all result outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      win_cnt        <= '0;
      scan_idx       <= '0;
      best_idx       <= '0;
      best_cnt       <= '0;
      best_tie       <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      valid_o        <= 1'b0;
      winner_o       <= '0;
      winner_count_o <= '0;
      tie_o          <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            valid_o  <= 1'b0;
            tie_o    <= 1'b0;
            busy_o   <= 1'b1;
            scan_idx <= '0;
            if (win_len_i != '0) begin
              win_cnt <= win_len_i;
              state   <= INTEGRATE;
            end else begin
              state   <= SCAN;
            end
          end else begin
            busy_o <= 1'b0;
          end
        end
        INTEGRATE: begin
          if (en_i) begin
            win_cnt <= win_cnt - 1'b1;
            if (win_cnt == WIN_W'(1)) begin
              scan_idx <= '0;
              state    <= SCAN;
            end
          end
        end
        SCAN: begin
          if (scan_idx == '0) begin
            best_idx <= '0;
            best_cnt <= scan_cnt;
            best_tie <= 1'b0;
          end else if (scan_cnt > best_cnt) begin
            best_idx <= scan_idx;
            best_cnt <= scan_cnt;
            best_tie <= 1'b0;
          end else if (scan_cnt == best_cnt) begin
            best_tie <= 1'b1;
          end
          if (scan_idx == IDX_W'(NUM_CH - 1)) begin
            scan_idx <= '0;
            state    <= REPORT;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        REPORT: begin
          winner_o       <= best_idx;
          winner_count_o <= best_cnt;
          tie_o          <= best_tie;
          done_o         <= 1'b1;
          valid_o        <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
